// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands consumed DIGIT bits per clock, LSB first,
// behind a start/done handshake. Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Handshake: an operation is accepted on a rising edge where start=1 and ready=1.
    // ready is simply ~busy, so a start in the done cycle chains the next operation.
    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            last_cycle;

    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic            carry;

    logic [DIGIT:0]        dsum;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]      res_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        last_cycle = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(N - 1)) begin
                    last_cycle = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = (state == RUN);
    assign ready = ~busy;

    // One digit of the ripple: operands sit LSB-aligned in their shift registers.
    assign dsum    = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    assign res_cat = {dsum[DIGIT-1:0], res_sr};
    assign res_nxt = res_cat[WIDTH+DIGIT-1:DIGIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            a_sr   <= a;
            b_sr   <= b ^ {WIDTH{sub}};
            res_sr <= '0;
            carry  <= cin ^ sub;
        end else if (state == RUN) begin
            cnt    <= cnt + 1'b1;
            a_sr   <= a_sr >> DIGIT;
            b_sr   <= b_sr >> DIGIT;
            res_sr <= res_nxt;
            carry  <= dsum[DIGIT];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            done <= last_cycle;
            if (last_cycle) begin
                sum  <= res_nxt;
                cout <= dsum[DIGIT];
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit and the two operand MSBs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (last_cycle) begin
            ovf <= (a_sr[DIGIT-1] ^ b_sr[DIGIT-1] ^ dsum[DIGIT-1]) ^ dsum[DIGIT];
        end
    end
`endif

endmodule
